rnn_layer_seq: RTL and testbench
================================

# rnn_layer_seq

Parametrised, time-multiplexed recurrent layer: NUM_CELLS neurons share one signed fixed-point MAC, each computing h_t[j] = hardtanh(b[j] + Σ W[j][i]·x[i] + Σ U[j][k]·h_{t-1}[k]). It replaces fixed per-neuron cell instances in our RNN top levels. It adds a programmable weight store, held recurrent state and valid/ready handshakes, and it chains layer-to-layer (out_* to in_*).

## Interface
- DATA_WIDTH, 16: bits per signed fixed-point value
- FRACT_WIDTH, 8: fraction bits (1.0 = 1<<FRACT_WIDTH)
- NUM_IN, 3: inputs per sample
- NUM_CELLS, 2: neurons in the layer
- ADDR_WIDTH, 8: weight address width; must cover NUM_CELLS*ROW
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  layer can accept a sample
- in_data  in  NUM_IN*DATA_WIDTH  x[i] at bits [i*DATA_WIDTH +: DATA_WIDTH]
- clear_state  in  1  zero recurrent state h_{t-1}
- w_we  in  1  weight write strobe
- w_addr  in  ADDR_WIDTH  weight address
- w_data  in  DATA_WIDTH  weight value
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_CELLS*DATA_WIDTH  h_t[j] at bits [j*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Weight map: ROW = NUM_IN+NUM_CELLS+1, so the default ROW is 6. Row j starts at j*ROW.
- Row layout: columns 0..NUM_IN-1 hold W. The next NUM_CELLS columns hold U. The last column holds the bias.
- Weight writes are accepted only in IDLE. Writes in other states, or to address ≥ NUM_CELLS*ROW, are dropped.
- FSM states are IDLE, MAC, ACT and OUT.
- IDLE: in_ready=1. When in_valid & in_ready, latch in_data, set cell j=0 and term t=0, load acc = sign-extended bias[0] << FRACT_WIDTH, then go to MAC.
- MAC: one term per cycle, acc += operand·weight. The operand is x[t] for t<NUM_IN, else h_prev[t-NUM_IN]. K = NUM_IN+NUM_CELLS terms are summed, then go to ACT.
- ACT: compute r = acc >>> FRACT_WIDTH (arithmetic shift, truncation toward −∞). Clamp r to [−(1<<FRACT_WIDTH), +(1<<FRACT_WIDTH)] and write it to h_next[j].
- After ACT, if j<NUM_CELLS-1: increment j, reload acc with bias[j+1], and return to MAC. Otherwise copy h_next to h_prev and out_data, then go to OUT.
- OUT: out_valid=1. out_data is held stable until out_ready. On the out_valid & out_ready cycle, go to IDLE.
- in_ready=0 in MAC, ACT and OUT. There is no overlap between samples.
- Products are full 2*DATA_WIDTH bits. acc is 2*DATA_WIDTH+8 bits wide, and no intermediate saturation is applied.
- clear_state is honoured only in IDLE and zeroes h_prev. If it coincides with an input acceptance, the clear applies first, so that sample sees h_{t-1}=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0. h_prev, h_next, acc and all weights are reset to 0.
- Latency: out_valid rises NUM_CELLS*(K+1) clock edges after the acceptance edge. The default is 12.
- Throughput: one sample per NUM_CELLS*(K+1)+1 cycles when out_ready=1. The default is 13.
- out_valid never deasserts without out_ready. out_data changes only on entry to OUT.
- rst asserted mid-operation aborts immediately. The block returns to reset values, including the weights, which must be reloaded.

## Configuration
- RNN_LAYER_RECURRENT_EN defined: U terms and h_prev are present. ROW = NUM_IN+NUM_CELLS+1 and K = NUM_IN+NUM_CELLS.
- RNN_LAYER_RECURRENT_EN undefined: the layer is purely feedforward. ROW = NUM_IN+1 and K = NUM_IN. h_prev storage is not built and clear_state is ignored.
- The default latency without the macro is 2*(3+1) = 8.

## Test plan
All values use the default parameters with RNN_LAYER_RECURRENT_EN defined; 1.0 = 0x0100.
- Reset: pulse rst → in_ready=1, out_valid=0, out_data=0; weights read back as 0 (a sample gives all-zero outputs).
- Feedforward: set W[0][0]=0x0100 (addr 0) and W[1][1]=0x0080 (addr 7), all others 0. Send x=(0x0080, 0x0100, 0) → out_valid exactly 12 edges after acceptance, with h=(0x0080, 0x0080).
- Saturation and bias: set W[0][0]=0x0100 and bias[0]=0x0040 (addr 5). x0=0x0300 → h0=0x0100. x0=0xFD00 → h0=0xFF00. x0=0 → h0=0x0040.
- Recurrence: set W[0][0]=0x0100 and U[0][0]=0x0100 (addr 3). Send x0=0x0040 twice → h0=0x0040, then 0x0080. Assert clear_state, resend → h0=0x0040.
- Backpressure and dropped writes: hold out_ready=0 for 5 cycles → out_data stable, in_ready=0, in_valid ignored. A w_we to addr 0 during MAC leaves the next result unchanged.
- Reset mid-MAC: assert rst 4 cycles after acceptance → out_valid stays 0, in_ready=1. A subsequent sample yields 0 because the weights were cleared.

Source files
------------

// File: rtl/rnn_layer_seq.sv
// rnn_layer_seq: time-multiplexed recurrent layer with one shared signed MAC, programmable weights and valid/ready handshakes.
// Define RNN_LAYER_RECURRENT_EN to build the U terms and the held state h_prev; otherwise the layer is feedforward.
module rnn_layer_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int NUM_IN = 3,
  parameter int NUM_CELLS = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0]    in_data,
  input  logic                            clear_state,
  input  logic                            w_we,
  input  logic [ADDR_WIDTH-1:0]           w_addr,
  input  logic [DATA_WIDTH-1:0]           w_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_CELLS*DATA_WIDTH-1:0] out_data
);
`ifdef RNN_LAYER_RECURRENT_EN
  localparam int NH = NUM_CELLS;
`else
  localparam int NH = 0;
`endif
  localparam int DW = DATA_WIDTH;
  localparam int K = NUM_IN + NH;
  localparam int ROW = K + 1;
  localparam int NW = NUM_CELLS * ROW;
  localparam int AW = 2 * DW + 8;
  localparam int TW = $clog2(K + 1);
  localparam int JW = $clog2(NUM_CELLS + 1);
  localparam logic signed [AW-1:0] HI = AW'(1) << FRACT_WIDTH;
  localparam logic signed [AW-1:0] LO = -HI;
  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;
  state_t state, state_nx;
  logic [TW-1:0] t;
  logic [JW-1:0] j, nb;
  logic signed [AW-1:0] acc, r, bias_acc;
  logic signed [DW-1:0] w [NW];
  logic signed [DW-1:0] x [NUM_IN];
  logic signed [DW-1:0] h_next [NUM_CELLS];
`ifdef RNN_LAYER_RECURRENT_EN
  logic signed [DW-1:0] h_prev [NUM_CELLS];
`else
  logic unused_clear;
  assign unused_clear = clear_state;
`endif
  logic signed [DW-1:0] op, wt, bias_nx, r_clamp;
  logic signed [2*DW-1:0] prod;
  logic [NUM_CELLS*DW-1:0] h_vec;
  logic last_t, last_j;
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  assign last_t = t == TW'(K - 1);
  assign last_j = j == JW'(NUM_CELLS - 1);
  always_comb begin
    op = '0;
    wt = '0;
    bias_nx = '0;
    nb = (state == IDLE) ? '0 : j + 1'b1;
    for (int i = 0; i < NUM_IN; i++) if (t == TW'(i)) op = x[i];
`ifdef RNN_LAYER_RECURRENT_EN
    for (int k = 0; k < NUM_CELLS; k++) if (t == TW'(NUM_IN + k)) op = h_prev[k];
`endif
    for (int c = 0; c < NUM_CELLS; c++) begin
      for (int i = 0; i < K; i++) if (j == JW'(c) && t == TW'(i)) wt = w[c*ROW+i];
      if (nb == JW'(c)) bias_nx = w[c*ROW+K];
    end
    prod = op * wt;
    bias_acc = AW'(bias_nx) <<< FRACT_WIDTH;
    r = acc >>> FRACT_WIDTH;
    r_clamp = DW'(r > HI ? HI : r < LO ? LO : r);
    for (int c = 0; c < NUM_CELLS; c++) h_vec[c*DW+:DW] = (j == JW'(c)) ? r_clamp : h_next[c];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? MAC : IDLE;
      MAC:  state_nx = last_t ? ACT : MAC;
      ACT:  state_nx = last_j ? OUT : MAC;
      OUT:  state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      j <= '0;
      acc <= '0;
      out_data <= '0;
      for (int a = 0; a < NW; a++) w[a] <= '0;
      for (int i = 0; i < NUM_IN; i++) x[i] <= '0;
      for (int c = 0; c < NUM_CELLS; c++) h_next[c] <= '0;
`ifdef RNN_LAYER_RECURRENT_EN
      for (int c = 0; c < NUM_CELLS; c++) h_prev[c] <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          for (int a = 0; a < NW; a++) if (w_we && w_addr == ADDR_WIDTH'(a)) w[a] <= w_data;
`ifdef RNN_LAYER_RECURRENT_EN
          if (clear_state) for (int c = 0; c < NUM_CELLS; c++) h_prev[c] <= '0;
`endif
          if (in_valid) begin
            for (int i = 0; i < NUM_IN; i++) x[i] <= in_data[i*DW+:DW];
            j <= '0;
            t <= '0;
            acc <= bias_acc;
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          t <= t + 1'b1;
        end
        ACT: begin
          for (int c = 0; c < NUM_CELLS; c++) h_next[c] <= h_vec[c*DW+:DW];
          if (!last_j) begin
            j <= j + 1'b1;
            t <= '0;
            acc <= bias_acc;
          end else begin
            out_data <= h_vec;
`ifdef RNN_LAYER_RECURRENT_EN
            for (int c = 0; c < NUM_CELLS; c++) h_prev[c] <= h_vec[c*DW+:DW];
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_layer_seq.sv
// tb_rnn_layer_seq: directed self-checking bench for rnn_layer_seq at default parameters.
module tb_rnn_layer_seq;
`ifdef RNN_LAYER_RECURRENT_EN
  localparam int ROW = 6;
  localparam int LAT = 12;
`else
  localparam int ROW = 4;
  localparam int LAT = 8;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_ready, clear_state = 0, w_we = 0, out_valid, out_ready = 1;
  logic [47:0] in_data = '0;
  logic [7:0] w_addr = '0;
  logic [15:0] w_data = '0;
  logic [31:0] out_data;
  int checks = 0, failures = 0;
  rnn_layer_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear_state(clear_state), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));
  always #5 clk = ~clk;
  task automatic write_w(input logic [7:0] a, input logic [15:0] d);
    w_addr = a; w_data = d; w_we = 1;
    @(posedge clk); #1 w_we = 0;
  endtask
  task automatic send(input logic [15:0] x0, x1, x2, input logic clr, output logic [15:0] h0, h1, output int lat);
    in_data = {x2, x1, x0}; in_valid = 1; clear_state = clr;
    @(posedge clk); #1 in_valid = 0; clear_state = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1 lat++; end
    h0 = out_data[15:0]; h1 = out_data[31:16];
    if (out_ready) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset();
    logic [15:0] h0, h1; int lat;
    repeat (2) @(posedge clk); #1;
    checks += 3;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 0; @(posedge clk); #1;
    send(16'h0100, 16'h0100, 16'h0100, 0, h0, h1, lat);
    checks += 2;
    if (h0 !== 16'h0) begin failures++; $display("FAIL reset_zero_h0 got=%h exp=0", h0); end
    if (h1 !== 16'h0) begin failures++; $display("FAIL reset_zero_h1 got=%h exp=0", h1); end
  endtask
  task automatic test_feedforward();
    logic [15:0] h0, h1; int lat;
    write_w(0, 16'h0100); write_w(8'(ROW + 1), 16'h0080);
    send(16'h0080, 16'h0100, 16'h0000, 0, h0, h1, lat);
    checks += 3;
    if (lat != LAT) begin failures++; $display("FAIL ff_latency got=%0d exp=%0d", lat, LAT); end
    if (h0 !== 16'h0080) begin failures++; $display("FAIL ff_h0 got=%h exp=0080", h0); end
    if (h1 !== 16'h0080) begin failures++; $display("FAIL ff_h1 got=%h exp=0080", h1); end
  endtask
  task automatic test_saturation();
    logic [15:0] h0, h1; int lat;
    logic [15:0] xs [3] = '{16'h0300, 16'hFD00, 16'h0000};
    logic [15:0] ex [3] = '{16'h0100, 16'hFF00, 16'h0040};
    write_w(8'(ROW + 1), 16'h0); write_w(8'(ROW - 1), 16'h0040);
    for (int i = 0; i < 3; i++) begin
      send(xs[i], 16'h0, 16'h0, 1, h0, h1, lat);
      checks += 2;
      if (h0 !== ex[i]) begin failures++; $display("FAIL sat_h0[%0d] got=%h exp=%h", i, h0, ex[i]); end
      if (h1 !== 16'h0) begin failures++; $display("FAIL sat_h1[%0d] got=%h exp=0000", i, h1); end
    end
    write_w(8'(ROW - 1), 16'h0);
  endtask
  task automatic test_recurrence();
`ifdef RNN_LAYER_RECURRENT_EN
    logic [15:0] h0, h1; int lat;
    logic [15:0] ex [3] = '{16'h0040, 16'h0080, 16'h00C0};
    write_w(3, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      send(16'h0040, 16'h0, 16'h0, i == 0, h0, h1, lat);
      checks++;
      if (h0 !== ex[i]) begin failures++; $display("FAIL rec_h0[%0d] got=%h exp=%h", i, h0, ex[i]); end
    end
    clear_state = 1; @(posedge clk); #1 clear_state = 0;
    send(16'h0040, 16'h0, 16'h0, 0, h0, h1, lat);
    checks++;
    if (h0 !== 16'h0040) begin failures++; $display("FAIL rec_after_clear got=%h exp=0040", h0); end
`endif
  endtask
  task automatic test_backpressure();
    logic [15:0] h0, h1; int lat;
    out_ready = 0;
    send(16'h0050, 16'h0, 16'h0, 1, h0, h1, lat);
    checks += 2;
    if (lat != LAT) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
    if (h0 !== 16'h0050) begin failures++; $display("FAIL bp_h0 got=%h exp=0050", h0); end
    in_valid = 1; in_data = {16'h0, 16'h0, 16'h0100};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h0000_0050) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h exp v=1 r=0 d=00000050", i, out_valid, in_ready, out_data);
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask
  task automatic test_dropped_writes();
    logic [15:0] h0, h1; int lat;
    in_data = {16'h0, 16'h0, 16'h0040}; in_valid = 1; clear_state = 1;
    @(posedge clk); #1 in_valid = 0; clear_state = 0;
    @(posedge clk); #1 w_addr = 0; w_data = 16'h7FFF; w_we = 1;
    @(posedge clk); #1 w_we = 0;
    lat = 2;
    while (!out_valid && lat < 100) begin @(posedge clk); #1 lat++; end
    checks += 2;
    if (lat != LAT) begin failures++; $display("FAIL drop_latency got=%0d exp=%0d", lat, LAT); end
    if (out_data[15:0] !== 16'h0040) begin failures++; $display("FAIL drop_cur_h0 got=%h exp=0040", out_data[15:0]); end
    @(posedge clk); #1;
    write_w(8'h80, 16'h7FFF);
    send(16'h0040, 16'h0, 16'h0, 1, h0, h1, lat);
    checks++;
    if (h0 !== 16'h0040) begin failures++; $display("FAIL drop_next_h0 got=%h exp=0040", h0); end
  endtask
  task automatic test_reset_mid();
    logic [15:0] h0, h1; int lat; bit seen = 0;
    in_data = {16'h0, 16'h0, 16'h0100}; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk); #1 rst = 1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_state got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < LAT + 4; i++) begin @(posedge clk); #1 if (out_valid) seen = 1; end
    if (seen) begin failures++; $display("FAIL midrst_no_output got=1 exp=0"); end
    send(16'h0100, 16'h0100, 16'h0100, 0, h0, h1, lat);
    checks += 3;
    if (lat != LAT) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
    if (h0 !== 16'h0) begin failures++; $display("FAIL midrst_h0 got=%h exp=0000", h0); end
    if (h1 !== 16'h0) begin failures++; $display("FAIL midrst_h1 got=%h exp=0000", h1); end
  endtask
  initial begin
    test_reset();
    test_feedforward();
    test_saturation();
    test_recurrence();
    test_backpressure();
    test_dropped_writes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
